keygen_sequencer: RTL

//  Parametrised control sequencer for ML-DSA/Dilithium key generation, for any (K,L) security level.

---
 rtl/keygen_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/keygen_sequencer.sv
// keygen_sequencer: issues ML-DSA keygen datapath start strobes in dependency order.
// Also collects the done pulses, runs a per-stage watchdog and counts busy cycles.
module keygen_sequencer #(
    parameter int K       = 6,
    parameter int L       = 5,
    parameter int TIMEOUT = 1048576,
    parameter int CNT_W   = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_i,
    input  logic [255:0]     seed_i,
    output logic [271:0]     seed_buf_o,
    output logic             shake1_start_o,
    output logic             expand_start_o,
    output logic             etal_start_o,
    output logic             etak_start_o,
    output logic             ntt_start_o,
    output logic             mul_start_o,
    output logic             invntt_start_o,
    output logic             hash_start_o,
    input  logic             shake1_done_i,
    input  logic             expand_done_i,
    input  logic             etal_done_i,
    input  logic             etak_done_i,
    input  logic             ntt_done_i,
    input  logic             mul_done_i,
    input  logic             invntt_done_i,
    input  logic             hash_done_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o,
    output logic [2:0]       stage_o,
    output logic [CNT_W-1:0] cycles_o
);
    localparam int WD_W = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, SEED, SAMPLE, MUL, INVNTT, HASH, DONE, ERROR} state_t;

    state_t           state_q, state_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [3:0]       flg_q, flg_d, flg_now;
    logic [7:0]       stb_q, stb_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic [271:0]     seed_buf_q, seed_buf_d;
    logic             busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic             running, accept, advance;

    always_comb begin
        running = state_q inside {SEED, SAMPLE, MUL, INVNTT, HASH};
        accept = start_i && !running;
        // flag bits: 0 expand (fx), 1 etal (fl), 2 etak (fk), 3 ntt (fn); ntt only counts once launched
        flg_now = flg_q | {ntt_done_i & flg_q[1], etak_done_i, etal_done_i, expand_done_i};
        advance = (state_q == SEED && shake1_done_i)
            || (state_q == SAMPLE && flg_now[0] && flg_now[2] && flg_now[3])
            || (state_q == MUL && mul_done_i)
            || (state_q == INVNTT && invntt_done_i)
            || (state_q == HASH && hash_done_i);
        // progress beats the watchdog when both land in the same cycle
        state_d = accept ? SEED
            : !running ? state_q
            : advance ? state_t'(state_q + 3'd1)
            : (wd_q + 1'b1 == WD_LAST) ? ERROR
            : state_q;
        wd_d = (state_d != state_q || !running) ? '0 : wd_q + 1'b1;
        flg_d = state_d == SEED ? 4'b0 : state_q == SAMPLE ? flg_now : flg_q;
        stb_d = {
            state_q == INVNTT && state_d == HASH,
            state_q == MUL && state_d == INVNTT,
            state_q == SAMPLE && state_d == MUL,
            state_q == SAMPLE && state_d == SAMPLE && etal_done_i && !flg_q[1],
            {3{state_q == SEED && state_d == SAMPLE}},
            accept
        };
        busy_d = state_d inside {SEED, SAMPLE, MUL, INVNTT, HASH};
        done_d = state_q == HASH && state_d == DONE;
        error_d = state_d == ERROR;
        cycles_d = accept ? '0 : (running && cycles_q != '1) ? cycles_q + 1'b1 : cycles_q;
        seed_buf_d = accept ? {8'(L), 8'(K), seed_i} : seed_buf_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            wd_q       <= '0;
            flg_q      <= '0;
            stb_q      <= '0;
            cycles_q   <= '0;
            seed_buf_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wd_q       <= wd_d;
            flg_q      <= flg_d;
            stb_q      <= stb_d;
            cycles_q   <= cycles_d;
            seed_buf_q <= seed_buf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign seed_buf_o     = seed_buf_q;
    assign shake1_start_o = stb_q[0];
    assign expand_start_o = stb_q[1];
    assign etal_start_o   = stb_q[2];
    assign etak_start_o   = stb_q[3];
    assign ntt_start_o    = stb_q[4];
    assign mul_start_o    = stb_q[5];
    assign invntt_start_o = stb_q[6];
    assign hash_start_o   = stb_q[7];
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign stage_o        = state_q;
    assign cycles_o       = cycles_q;
endmodule
